// File: rtl/axis_packet_filter_pkg.sv
// Shared types for the store-and-forward AXI-Stream packet filter.
package axis_packet_filter_pkg;

   typedef enum logic [2:0] {
      REASON_NONE     = 3'd0,
      REASON_ERROR    = 3'd1,
      REASON_OVERFLOW = 3'd2,
      REASON_OVERSIZE = 3'd3,
      REASON_RUNT     = 3'd4
   } drop_reason_t;

   typedef enum logic {
      STORE   = 1'b0,
      DISCARD = 1'b1
   } state_t;

endpackage

// File: rtl/axis_packet_filter_ram_sdp.sv
// Simple dual-port packet buffer: one write port, one read port with a
// registered read. The read register holds its value while rd_en is low so
// a prefetched word survives a downstream stall.
module axis_packet_filter_ram_sdp #(
   parameter int WIDTH     = 10,
   parameter int ADDR_BITS = 8
) (
   input  logic                 clk,
   input  logic                 wr_en,
   input  logic [ADDR_BITS-1:0] wr_addr,
   input  logic [WIDTH-1:0]     wr_data,
   input  logic                 rd_en,
   input  logic [ADDR_BITS-1:0] rd_addr,
   output logic [WIDTH-1:0]     rd_data
);

   logic [WIDTH-1:0] mem [2**ADDR_BITS];
   logic [WIDTH-1:0] rd_data_q;

   // Storage write and registered read; no reset, contents are only trusted
   // once the owning pointers say a word is committed.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/axis_packet_filter.sv
// Store-and-forward AXI-Stream packet filter. Whole packets are written
// speculatively and only become readable once a clean tlast commits them;
// bad packets are rewound out of the buffer and counted as drops.
module axis_packet_filter
   import axis_packet_filter_pkg::*;
#(
   parameter int AXIS_BYTES     = 1,
   parameter int AXIS_USER_BITS = 1,
   parameter int LOG2_DEPTH     = 8,
   parameter int MAX_BEATS      = 2**LOG2_DEPTH,
   parameter int MIN_BEATS      = 1,
   parameter int COUNT_BITS     = 32
) (
   input  logic                      clk,
   input  logic                      sreset,
   input  logic                      axis_i_tvalid,
   output logic                      axis_i_tready,
   input  logic                      axis_i_tlast,
   input  logic [AXIS_BYTES*8-1:0]   axis_i_tdata,
   input  logic [AXIS_USER_BITS-1:0] axis_i_tuser,
   input  logic                      axis_i_terror,
   output logic                      axis_o_tvalid,
   input  logic                      axis_o_tready,
   output logic                      axis_o_tlast,
   output logic [AXIS_BYTES*8-1:0]   axis_o_tdata,
   output logic [AXIS_USER_BITS-1:0] axis_o_tuser,
   output logic [COUNT_BITS-1:0]     o_good_count,
   output logic [COUNT_BITS-1:0]     o_drop_count,
   output logic                      o_drop_pulse,
   output logic [2:0]                o_drop_reason
);

   localparam int PTR_W  = LOG2_DEPTH + 1;
   localparam int WORD_W = AXIS_BYTES*8 + AXIS_USER_BITS + 1;
   localparam logic [PTR_W-1:0] DEPTH_PTR = PTR_W'(2**LOG2_DEPTH);
   localparam logic [PTR_W-1:0] MAX_CNT   = PTR_W'(MAX_BEATS);
   localparam logic [PTR_W-1:0] MIN_CNT   = PTR_W'(MIN_BEATS);

   state_t                  state_q, state_d;
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]        commit_ptr_q, commit_ptr_d;
   logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]        beat_cnt_q, beat_cnt_d;
   logic [COUNT_BITS-1:0]   good_count_q, good_count_d;
   logic [COUNT_BITS-1:0]   drop_count_q, drop_count_d;
   logic                    drop_pulse_q, drop_pulse_d;
   drop_reason_t            drop_reason_q, drop_reason_d;
   logic                    ram_valid_q, ram_valid_d;
   logic                    out_valid_q, out_valid_d;
   logic [WORD_W-1:0]       out_word_q, out_word_d;

   logic                    in_accept;
   logic                    buf_full;
   logic [PTR_W-1:0]        beat_cnt_inc;
   drop_reason_t            reason;
   logic                    ram_we;
   logic                    ram_re;
   logic                    out_take;
   logic                    out_load;
   logic [WORD_W-1:0]       ram_wdata;
   logic [WORD_W-1:0]       ram_rdata;

   assign axis_i_tready = !sreset;
   assign in_accept     = axis_i_tvalid && axis_i_tready;
   assign buf_full      = (wr_ptr_q - rd_ptr_q) == DEPTH_PTR;
   assign beat_cnt_inc  = beat_cnt_q + 1'b1;
   assign ram_wdata     = {axis_i_tlast, axis_i_tuser, axis_i_tdata};

   // Classify the incoming beat; earlier tests win when several apply.
   always_comb begin
      reason = REASON_NONE;
      if (axis_i_terror) begin
         reason = REASON_ERROR;
      end else if (buf_full) begin
         reason = REASON_OVERFLOW;
      end else if (beat_cnt_inc > MAX_CNT) begin
         reason = REASON_OVERSIZE;
      end else if (axis_i_tlast && (beat_cnt_inc < MIN_CNT)) begin
         reason = REASON_RUNT;
      end
   end

   // Input FSM: speculative write, commit on clean tlast, rewind on a drop.
   always_comb begin
      state_d       = state_q;
      wr_ptr_d      = wr_ptr_q;
      commit_ptr_d  = commit_ptr_q;
      beat_cnt_d    = beat_cnt_q;
      good_count_d  = good_count_q;
      drop_count_d  = drop_count_q;
      drop_pulse_d  = 1'b0;
      drop_reason_d = drop_reason_q;
      ram_we        = 1'b0;
      case (state_q)
         STORE: begin
            if (in_accept) begin
               if (reason != REASON_NONE) begin
                  wr_ptr_d      = commit_ptr_q;
                  beat_cnt_d    = '0;
                  drop_pulse_d  = 1'b1;
                  drop_reason_d = reason;
                  if (drop_count_q != '1) begin
                     drop_count_d = drop_count_q + 1'b1;
                  end
                  if (!axis_i_tlast) begin
                     state_d = DISCARD;
                  end
               end else begin
                  ram_we   = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  if (axis_i_tlast) begin
                     commit_ptr_d = wr_ptr_q + 1'b1;
                     beat_cnt_d   = '0;
                     if (good_count_q != '1) begin
                        good_count_d = good_count_q + 1'b1;
                     end
                  end else begin
                     beat_cnt_d = beat_cnt_inc;
                  end
               end
            end
         end
         DISCARD: begin
            if (in_accept && axis_i_tlast) begin
               state_d = STORE;
            end
         end
         default: state_d = STORE;
      endcase
   end

   assign out_take = out_valid_q && axis_o_tready;
   assign out_load = ram_valid_q && (!out_valid_q || out_take);
   assign ram_re   = (rd_ptr_q != commit_ptr_q) && (!ram_valid_q || out_load);

   // Two-stage prefetch: RAM read register feeds the output register, so a
   // fresh word is always one step behind and the stream can run gap-free.
   always_comb begin
      rd_ptr_d    = rd_ptr_q;
      ram_valid_d = ram_valid_q;
      out_valid_d = out_valid_q;
      out_word_d  = out_word_q;
      if (out_take) begin
         out_valid_d = 1'b0;
      end
      if (out_load) begin
         out_valid_d = 1'b1;
         out_word_d  = ram_rdata;
         ram_valid_d = 1'b0;
      end
      if (ram_re) begin
         rd_ptr_d    = rd_ptr_q + 1'b1;
         ram_valid_d = 1'b1;
      end
   end

   // State register; reset discards everything, including committed data.
   always_ff @(posedge clk) begin
      if (sreset) begin
         state_q       <= STORE;
         wr_ptr_q      <= '0;
         commit_ptr_q  <= '0;
         rd_ptr_q      <= '0;
         beat_cnt_q    <= '0;
         good_count_q  <= '0;
         drop_count_q  <= '0;
         drop_pulse_q  <= 1'b0;
         drop_reason_q <= REASON_NONE;
         ram_valid_q   <= 1'b0;
         out_valid_q   <= 1'b0;
         out_word_q    <= '0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         commit_ptr_q  <= commit_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         beat_cnt_q    <= beat_cnt_d;
         good_count_q  <= good_count_d;
         drop_count_q  <= drop_count_d;
         drop_pulse_q  <= drop_pulse_d;
         drop_reason_q <= drop_reason_d;
         ram_valid_q   <= ram_valid_d;
         out_valid_q   <= out_valid_d;
         out_word_q    <= out_word_d;
      end
   end

   axis_packet_filter_ram_sdp #(
      .WIDTH     (WORD_W),
      .ADDR_BITS (LOG2_DEPTH)
   ) u_ram_sdp (
      .clk     (clk),
      .wr_en   (ram_we),
      .wr_addr (wr_ptr_q[LOG2_DEPTH-1:0]),
      .wr_data (ram_wdata),
      .rd_en   (ram_re),
      .rd_addr (rd_ptr_q[LOG2_DEPTH-1:0]),
      .rd_data (ram_rdata)
   );

   assign axis_o_tvalid = out_valid_q;
   assign {axis_o_tlast, axis_o_tuser, axis_o_tdata} = out_word_q;
   assign o_good_count  = good_count_q;
   assign o_drop_count  = drop_count_q;
   assign o_drop_pulse  = drop_pulse_q;
   assign o_drop_reason = drop_reason_q;

endmodule

// File: tb/tb_axis_packet_filter.sv
// Directed and randomised bench for axis_packet_filter with a small
// 16-entry buffer, packet length limits 2..12 and 5-bit counters so that
// counter saturation is reached during the random phase.
module tb_axis_packet_filter;

   localparam int DEPTH = 16;
   localparam int MAXB  = 12;
   localparam int MINB  = 2;
   localparam int CB    = 5;

   localparam logic [2:0] R_NONE     = 3'd0;
   localparam logic [2:0] R_ERROR    = 3'd1;
   localparam logic [2:0] R_OVERFLOW = 3'd2;
   localparam logic [2:0] R_OVERSIZE = 3'd3;
   localparam logic [2:0] R_RUNT     = 3'd4;

   typedef struct packed {
      logic       last;
      logic [1:0] user;
      logic [7:0] data;
   } beat_t;

   logic          clk = 1'b0;
   logic          sreset;
   logic          inTvalid;
   logic          inTready;
   logic          inTlast;
   logic [7:0]    inTdata;
   logic [1:0]    inTuser;
   logic          inTerror;
   logic          outTvalid;
   logic          outTready;
   logic          outTlast;
   logic [7:0]    outTdata;
   logic [1:0]    outTuser;
   logic [CB-1:0] goodCount;
   logic [CB-1:0] dropCount;
   logic          dropPulse;
   logic [2:0]    dropReason;

   beat_t         sb[$];
   int            checks = 0;
   int            errors = 0;
   int            pulseCount = 0;
   int            outBeats = 0;
   int            dropTotal = 0;
   bit            randomReady = 0;
   bit            prevStall = 0;
   beat_t         prevBeat;
   logic [CB-1:0] expGood;
   logic [CB-1:0] expDrop;
   logic [2:0]    expReason;

   always #5 clk = ~clk;

   axis_packet_filter #(
      .AXIS_BYTES     (1),
      .AXIS_USER_BITS (2),
      .LOG2_DEPTH     (4),
      .MAX_BEATS      (MAXB),
      .MIN_BEATS      (MINB),
      .COUNT_BITS     (CB)
   ) dut (
      .clk           (clk),
      .sreset        (sreset),
      .axis_i_tvalid (inTvalid),
      .axis_i_tready (inTready),
      .axis_i_tlast  (inTlast),
      .axis_i_tdata  (inTdata),
      .axis_i_tuser  (inTuser),
      .axis_i_terror (inTerror),
      .axis_o_tvalid (outTvalid),
      .axis_o_tready (outTready),
      .axis_o_tlast  (outTlast),
      .axis_o_tdata  (outTdata),
      .axis_o_tuser  (outTuser),
      .o_good_count  (goodCount),
      .o_drop_count  (dropCount),
      .o_drop_pulse  (dropPulse),
      .o_drop_reason (dropReason)
   );

   // One comparison: counted, and reported on mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // Advance one cycle; inputs change 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (randomReady) outTready = ($urandom_range(0, 3) != 0);
   endtask

   // Output monitor: scoreboard pops on handshake, stability under stall,
   // and a tally of drop strobes.
   always @(negedge clk) begin
      if (sreset) begin
         prevStall = 0;
      end else begin
         if (dropPulse) pulseCount++;
         if (prevStall)
            checkOutput("stall_stable", 32'({outTvalid, outTlast, outTuser, outTdata}),
                        32'({1'b1, prevBeat}));
         if (outTvalid && outTready) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_beat", 32'(sb.size()), 32'd1);
            end else begin
               beat_t expBeat;
               expBeat = sb.pop_front();
               checkOutput("beat", 32'({outTlast, outTuser, outTdata}), 32'(expBeat));
            end
            outBeats++;
         end
         prevStall = outTvalid && !outTready;
         prevBeat  = {outTlast, outTuser, outTdata};
      end
   end

   // Drive one packet, predicting its fate and queueing its beats if good.
   task automatic applyStimulus(input int len, input logic [15:0] errMask,
                                input bit forceOverflow, input bit gate);
      beat_t      pkt[16];
      logic [2:0] reason;
      int         budget;
      if (gate) begin
         budget = 0;
         while ((sb.size() + len > DEPTH) && (budget < 3000)) begin
            tick();
            budget++;
         end
         if (budget >= 3000) checkOutput("gate_timeout", 32'(sb.size() + len), 32'(DEPTH));
      end
      for (int i = 0; i < len; i++) begin
         pkt[i].data = 8'($urandom);
         pkt[i].user = 2'($urandom_range(0, 3));
         pkt[i].last = (i == len - 1);
      end
      reason = R_NONE;
      if (forceOverflow) begin
         reason = R_OVERFLOW;
      end else begin
         for (int i = 1; i <= len; i++) begin
            if (errMask[i-1]) begin
               reason = R_ERROR;
               break;
            end
            if (i > MAXB) begin
               reason = R_OVERSIZE;
               break;
            end
            if ((i == len) && (i < MINB)) reason = R_RUNT;
         end
      end
      if (reason == R_NONE) begin
         for (int i = 0; i < len; i++) sb.push_back(pkt[i]);
         if (expGood != '1) expGood++;
      end else begin
         if (expDrop != '1) expDrop++;
         expReason = reason;
         dropTotal++;
      end
      for (int i = 0; i < len; i++) begin
         inTvalid = 1'b1;
         inTdata  = pkt[i].data;
         inTuser  = pkt[i].user;
         inTlast  = pkt[i].last;
         inTerror = errMask[i];
         tick();
      end
      inTvalid = 1'b0;
      inTlast  = 1'b0;
      inTerror = 1'b0;
   endtask

   task automatic waitDrain(input string tag);
      int n;
      n = 0;
      while (!((sb.size() == 0) && (outTvalid == 1'b0)) && (n < 3000)) begin
         tick();
         n++;
      end
      checkOutput({tag, "_drain"}, 32'(sb.size()), 32'd0);
      checkOutput({tag, "_idle"}, 32'(outTvalid), 32'd0);
   endtask

   task automatic checkCounts(input string tag);
      checkOutput({tag, "_good"}, 32'(goodCount), 32'(expGood));
      checkOutput({tag, "_drop"}, 32'(dropCount), 32'(expDrop));
      checkOutput({tag, "_reason"}, 32'(dropReason), 32'(expReason));
      checkOutput({tag, "_pulses"}, 32'(pulseCount), 32'(dropTotal));
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_in_tready"}, 32'(inTready), 32'd0);
      checkOutput({tag, "_tvalid"}, 32'(outTvalid), 32'd0);
      checkOutput({tag, "_tlast"}, 32'(outTlast), 32'd0);
      checkOutput({tag, "_tdata"}, 32'(outTdata), 32'd0);
      checkOutput({tag, "_tuser"}, 32'(outTuser), 32'd0);
      checkOutput({tag, "_good"}, 32'(goodCount), 32'd0);
      checkOutput({tag, "_drop"}, 32'(dropCount), 32'd0);
      checkOutput({tag, "_pulse"}, 32'(dropPulse), 32'd0);
      checkOutput({tag, "_reason"}, 32'(dropReason), 32'd0);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #800000;
      $display("[TB] FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      sreset    = 1'b1;
      inTvalid  = 1'b0;
      inTlast   = 1'b0;
      inTdata   = '0;
      inTuser   = '0;
      inTerror  = 1'b0;
      outTready = 1'b0;
      expGood   = '0;
      expDrop   = '0;
      expReason = R_NONE;
      repeat (3) tick();
      checkResetState("reset");
      sreset = 1'b0;
      tick();
      checkOutput("in_tready", 32'(inTready), 32'd1);

      $display("[TB] three clean 4-beat packets");
      outTready = 1'b1;
      applyStimulus(4, 16'h0, 0, 0);
      checkOutput("lat_n", 32'(outTvalid), 32'd0);
      tick();
      checkOutput("lat_n1", 32'(outTvalid), 32'd0);
      tick();
      checkOutput("lat_n2", 32'(outTvalid), 32'd1);
      applyStimulus(4, 16'h0, 0, 0);
      applyStimulus(4, 16'h0, 0, 0);
      waitDrain("t1");
      checkCounts("t1");
      checkOutput("t1_beats", 32'(outBeats), 32'd12);

      $display("[TB] error on beat 3 of 6, then clean 2-beat packet");
      applyStimulus(6, 16'b100, 0, 0);
      applyStimulus(2, 16'h0, 0, 0);
      waitDrain("t2");
      checkCounts("t2");
      checkOutput("t2_beats", 32'(outBeats), 32'd14);

      $display("[TB] overflow with downstream stalled");
      outTready = 1'b0;
      applyStimulus(10, 16'h0, 0, 0);
      applyStimulus(10, 16'h0, 1, 0);
      checkCounts("t3");
      repeat (5) tick();
      outTready = 1'b1;
      waitDrain("t3");
      checkOutput("t3_beats", 32'(outBeats), 32'd24);

      $display("[TB] length limits");
      applyStimulus(13, 16'h0, 0, 0);
      checkOutput("oversize_reason", 32'(dropReason), 32'(R_OVERSIZE));
      applyStimulus(1, 16'h0, 0, 0);
      checkOutput("runt_reason", 32'(dropReason), 32'(R_RUNT));
      checkOutput("runt_pulse", 32'(dropPulse), 32'd1);
      tick();
      checkOutput("runt_pulse_clear", 32'(dropPulse), 32'd0);
      applyStimulus(12, 16'h0, 0, 0);
      applyStimulus(2, 16'h0, 0, 0);
      waitDrain("t4");
      checkCounts("t4");
      checkOutput("t4_beats", 32'(outBeats), 32'd38);

      $display("[TB] random packets with random downstream ready");
      randomReady = 1;
      for (int p = 0; p < 200; p++) begin
         int          len;
         logic [15:0] mask;
         len  = $urandom_range(1, 13);
         mask = '0;
         for (int b = 0; b < len; b++) mask[b] = ($urandom_range(0, 9) == 0);
         applyStimulus(len, mask, 0, 1);
         repeat ($urandom_range(0, 2)) tick();
      end
      waitDrain("t5");
      randomReady = 0;
      outTready   = 1'b1;
      checkCounts("t5");

      $display("[TB] reset with data buffered and a packet in flight");
      outTready = 1'b0;
      applyStimulus(4, 16'h0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         inTvalid = 1'b1;
         inTdata  = 8'(8'hA0 + i);
         inTuser  = 2'd1;
         inTlast  = 1'b0;
         tick();
      end
      inTvalid = 1'b0;
      sreset   = 1'b1;
      tick();
      checkResetState("t6");
      sreset = 1'b0;
      sb.delete();
      expGood    = '0;
      expDrop    = '0;
      expReason  = R_NONE;
      dropTotal  = 0;
      pulseCount = 0;
      outBeats   = 0;
      outTready  = 1'b1;
      tick();
      applyStimulus(3, 16'h0, 0, 0);
      waitDrain("t6");
      checkCounts("t6");
      checkOutput("t6_beats", 32'(outBeats), 32'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
